// File: rtl/glitch_seq_gen.sv
// glitch_seq_gen: after a synchronised trigger edge, emits a train of 1..N glitch
// pulses with programmable delay, width and gap. Config is latched at arm time.
module glitch_seq_gen #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned NUM_W      = 8,
  parameter bit          GLITCH_POL = 1'b1,
  parameter bit          TRIG_EDGE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             abort,
  input  logic             trig_in,
  input  logic [CNT_W-1:0] delay_cfg,
  input  logic [CNT_W-1:0] width_cfg,
  input  logic [CNT_W-1:0] gap_cfg,
  input  logic [NUM_W-1:0] count_cfg,
  output logic             glitch,
  output logic             armed,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulse_idx
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_DELAY = 3'd2,
    S_PULSE = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [NUM_W-1:0] NUM_ONE = NUM_W'(1);

  // A zero width/gap would make a pulse or gap vanish; run it as one cycle instead.
  function automatic logic [CNT_W-1:0] nz_cnt(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_ONE : v;
  endfunction

  function automatic logic [NUM_W-1:0] nz_num(input logic [NUM_W-1:0] v);
    return (v == '0) ? NUM_ONE : v;
  endfunction

  state_t           state_q, state_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [NUM_W-1:0] idx_nx;
  logic [CNT_W-1:0] dly_q, dly_nx;
  logic [CNT_W-1:0] wid_q, wid_nx;
  logic [CNT_W-1:0] gap_q, gap_nx;
  logic [NUM_W-1:0] num_q, num_nx;
  logic             glitch_nx, armed_nx, busy_nx, done_nx;
  logic             more_pulses;

  logic trig_p0, trig_p1, trig_p2;
  logic edge_p3;
  logic edge_det;

  // Stage p0/p1: two-flop synchroniser; p2: delayed copy for edge detection.
  assign edge_det = TRIG_EDGE ? (trig_p2 & ~trig_p1) : (trig_p1 & ~trig_p2);

  // Synchronise the trigger and register the detected edge (stage p3).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_p0 <= 1'b0;
      trig_p1 <= 1'b0;
      trig_p2 <= 1'b0;
      edge_p3 <= 1'b0;
    end else begin
      trig_p0 <= trig_in;
      trig_p1 <= trig_p0;
      trig_p2 <= trig_p1;
      edge_p3 <= edge_det;
    end
  end

  // Widened compare so pulse_idx+1 cannot wrap at the top of the NUM_W range.
  assign more_pulses = ({1'b0, pulse_idx} + (NUM_W+1)'(1)) < {1'b0, num_q};

  // Next-state, counter and registered-output values for the sequencer.
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    idx_nx   = pulse_idx;
    dly_nx   = dly_q;
    wid_nx   = wid_q;
    gap_nx   = gap_q;
    num_nx   = num_q;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          dly_nx   = delay_cfg;
          wid_nx   = nz_cnt(width_cfg);
          gap_nx   = nz_cnt(gap_cfg);
          num_nx   = nz_num(count_cfg);
          cnt_nx   = '0;
          idx_nx   = '0;
          state_nx = S_ARMED;
        end
      end
      S_ARMED: begin
        if (edge_p3) begin
          if (dly_q == '0) begin
            state_nx = S_PULSE;
            cnt_nx   = wid_q;
          end else begin
            state_nx = S_DELAY;
            cnt_nx   = dly_q;
          end
        end
      end
      S_DELAY: begin
        if (cnt_q == CNT_ONE) begin
          state_nx = S_PULSE;
          cnt_nx   = wid_q;
        end else begin
          cnt_nx = cnt_q - CNT_ONE;
        end
      end
      S_PULSE: begin
        if (cnt_q == CNT_ONE) begin
          if (more_pulses) begin
            state_nx = S_GAP;
            cnt_nx   = gap_q;
          end else begin
            state_nx = S_DONE;
            cnt_nx   = '0;
          end
        end else begin
          cnt_nx = cnt_q - CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_ONE) begin
          state_nx = S_PULSE;
          cnt_nx   = wid_q;
          idx_nx   = pulse_idx + NUM_ONE;
        end else begin
          cnt_nx = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase

    // Abort overrides every other event, including a simultaneous arm.
    if (abort) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      idx_nx   = '0;
    end

    glitch_nx = (state_nx == S_PULSE) ? GLITCH_POL : ~GLITCH_POL;
    armed_nx  = (state_nx == S_ARMED);
    busy_nx   = (state_nx == S_DELAY) || (state_nx == S_PULSE) || (state_nx == S_GAP);
    done_nx   = (state_nx == S_DONE);
  end

  // State, counters, latched config and outputs; outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dly_q     <= '0;
      wid_q     <= '0;
      gap_q     <= '0;
      num_q     <= '0;
      pulse_idx <= '0;
      glitch    <= ~GLITCH_POL;
      armed     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_nx;
      cnt_q     <= cnt_nx;
      dly_q     <= dly_nx;
      wid_q     <= wid_nx;
      gap_q     <= gap_nx;
      num_q     <= num_nx;
      pulse_idx <= idx_nx;
      glitch    <= glitch_nx;
      armed     <= armed_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

endmodule
